gpio_access_arbiter: RTL and testbench

Two-port register front end for the `gpio` block. It owns the `gpio_dir` and `gpio_write` control registers and shares them between two requesters, for example a CPU bus bridge and a sequencer. Requests are served one at a time, using round-robin arbitration and a two-state FSM. Writes are masked per bit. Pin input reads come from a double-flop synchronized copy of `gpio_read`.

---
 rtl/gpio_access_arbiter.sv | 132 +++++++++++++
 tb/tb_gpio_access_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_access_arbiter.sv
// Two-requester register front end for the gpio block.
// Owns gpio_dir / gpio_write; round-robin, one access per two cycles.
module gpio_access_arbiter #(
  parameter int length = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        addr0,
  input  logic [1:0]        addr1,
  input  logic [length-1:0] wdata0,
  input  logic [length-1:0] wdata1,
  input  logic [length-1:0] mask0,
  input  logic [length-1:0] mask1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [length-1:0] rdata0,
  output logic [length-1:0] rdata1,
  output logic [length-1:0] gpio_dir,
  output logic [length-1:0] gpio_write,
  input  logic [length-1:0] gpio_read
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t            state;
  logic              rr_ptr;
  logic              owner;
  logic              op_we;
  logic [1:0]        op_addr;
  logic [length-1:0] op_wdata;
  logic [length-1:0] op_mask;
  logic [length-1:0] sync1;
  logic [length-1:0] sync2;

  logic              pick;
  logic              sel_we;
  logic [1:0]        sel_addr;
  logic [length-1:0] sel_wdata;
  logic [length-1:0] sel_mask;
  logic [length-1:0] sel_rd;

  // Only a tie consults rr_ptr; a lone request wins outright.
  assign pick      = (req0 & req1) ? rr_ptr : req1;
  assign sel_we    = pick ? we1 : we0;
  assign sel_addr  = pick ? addr1 : addr0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign sel_mask  = pick ? mask1 : mask0;

  always_comb begin
    sel_rd = '0;
    unique case (1'b1)
      (sel_addr == 2'd0): sel_rd = gpio_dir;
      (sel_addr == 2'd1): sel_rd = gpio_write;
      (sel_addr == 2'd2): sel_rd = sync2;
      (sel_addr == 2'd3): sel_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      owner      <= 1'b0;
      op_we      <= 1'b0;
      op_addr    <= 2'd0;
      op_wdata   <= '0;
      op_mask    <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      gpio_dir   <= '0;
      gpio_write <= '0;
      sync1      <= '0;
      sync2      <= '0;
    end else begin
      sync1 <= gpio_read;
      sync2 <= sync1;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            state    <= ACCESS;
            owner    <= pick;
            op_we    <= sel_we;
            op_addr  <= sel_addr;
            op_wdata <= sel_wdata;
            op_mask  <= sel_mask;
            gnt0     <= ~pick;
            gnt1     <= pick;
            done0    <= ~pick;
            done1    <= pick;
            // Registers cannot change before commit, so rdata
            // is already valid while done is high.
            if (!sel_we) begin
              if (pick) rdata1 <= sel_rd;
              else      rdata0 <= sel_rd;
            end
          end
        end
        ACCESS: begin
          state  <= IDLE;
          rr_ptr <= ~owner;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
          if (op_we) begin
            unique case (op_addr)
              2'd0: gpio_dir <= (gpio_dir & ~op_mask)
                              | (op_wdata & op_mask);
              2'd1: gpio_write <= (gpio_write & ~op_mask)
                                | (op_wdata & op_mask);
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_access_arbiter.sv
// Self-checking bench for gpio_access_arbiter.
// Transaction-level model plus directed literal checks.
module tb_gpio_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [3:0] wdata0, wdata1, mask0, mask1;
  logic       gnt0, gnt1, done0, done1;
  logic [3:0] rdata0, rdata1, gpio_dir, gpio_write, gpio_read;
  logic [3:0] ext_pins;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Driven pins read back what the block drives.
  assign gpio_read = (gpio_dir & gpio_write) | (~gpio_dir & ext_pins);

  gpio_access_arbiter #(.length(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .mask0(mask0), .mask1(mask1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1),
    .gpio_dir(gpio_dir), .gpio_write(gpio_write),
    .gpio_read(gpio_read)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Model: one pending transaction, served in the following cycle.
  logic       m_busy, m_owner, m_we, m_rr;
  logic [1:0] m_addr;
  logic [3:0] m_wd, m_mk, m_dir, m_out, m_s1, m_s2, m_rd0, m_rd1;

  wire       m_pick = (req0 && req1) ? m_rr : req1;
  wire       p_we   = m_pick ? we1 : we0;
  wire [1:0] p_addr = m_pick ? addr1 : addr0;
  wire [3:0] p_wd   = m_pick ? wdata1 : wdata0;
  wire [3:0] p_mk   = m_pick ? mask1 : mask0;

  function logic [3:0] rd_of(input logic [1:0] a);
    case (a)
      2'd0:    rd_of = m_dir;
      2'd1:    rd_of = m_out;
      2'd2:    rd_of = m_s2;
      default: rd_of = 4'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0; m_owner <= 1'b0; m_we <= 1'b0; m_rr <= 1'b0;
      m_addr <= 2'd0; m_wd <= 4'h0; m_mk <= 4'h0;
      m_dir <= 4'h0; m_out <= 4'h0; m_s1 <= 4'h0; m_s2 <= 4'h0;
      m_rd0 <= 4'h0; m_rd1 <= 4'h0;
    end else begin
      m_s1 <= gpio_read;
      m_s2 <= m_s1;
      if (m_busy) begin
        m_busy <= 1'b0;
        m_rr   <= !m_owner;
        if (m_we && m_addr == 2'd0)
          m_dir <= (m_dir & ~m_mk) | (m_wd & m_mk);
        if (m_we && m_addr == 2'd1)
          m_out <= (m_out & ~m_mk) | (m_wd & m_mk);
      end else if (req0 || req1) begin
        m_busy  <= 1'b1;
        m_owner <= m_pick;
        m_we    <= p_we;
        m_addr  <= p_addr;
        m_wd    <= p_wd;
        m_mk    <= p_mk;
        if (!p_we) begin
          if (m_pick) m_rd1 <= rd_of(p_addr);
          else        m_rd0 <= rd_of(p_addr);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_gnt0", gnt0, m_busy && !m_owner);
    chk("m_gnt1", gnt1, m_busy && m_owner);
    chk("m_done0", done0, m_busy && !m_owner);
    chk("m_done1", done1, m_busy && m_owner);
    chk("m_rdata0", rdata0, m_rd0);
    chk("m_rdata1", rdata1, m_rd1);
    chk("m_dir", gpio_dir, m_dir);
    chk("m_out", gpio_write, m_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Uncontended access: done must appear exactly one cycle later.
  task automatic access(input int who, input logic w,
                        input logic [1:0] a, input logic [3:0] d,
                        input logic [3:0] m, output logic [3:0] rd);
    if (who == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; mask0 = m;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; mask1 = m;
    end
    tick();
    if (who == 0) begin
      chk("lat_done0", done0, 1'b1);
      chk("lat_gnt1_idle", gnt1, 1'b0);
    end else begin
      chk("lat_done1", done1, 1'b1);
      chk("lat_gnt0_idle", gnt0, 1'b0);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    rd = (who == 0) ? rdata0 : rdata1;
  endtask

  logic [3:0] r;

  initial begin
    rst = 1'b0; ext_pins = 4'h0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    mask0 = 0; mask1 = 0;
    tick(); tick();
    chk("rst_dir", gpio_dir, 4'h0);
    chk("rst_out", gpio_write, 4'h0);
    chk("rst_gnt", {gnt0, gnt1, done0, done1}, 4'h0);
    chk("rst_rdata", {rdata0, rdata1}, 8'h00);
    rst = 1'b1;
    tick();

    // Contention right after reset: 0 first, 1 two cycles later.
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("cont_gnt_a", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    tick();
    chk("cont_idle", {gnt0, gnt1}, 2'b00);
    tick();
    chk("cont_gnt_b", {gnt0, gnt1}, 2'b01);
    req1 = 1'b0;
    tick();

    // Both held continuously: grants alternate.
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("alt_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // DIR then OUT, then PIN read through the sync path.
    access(0, 1'b1, 2'd0, 4'b1111, 4'b1111, r);
    chk("dir_1111", gpio_dir, 4'b1111);
    access(0, 1'b1, 2'd1, 4'b1010, 4'b1111, r);
    chk("out_1010", gpio_write, 4'b1010);
    repeat (4) tick();
    access(0, 1'b0, 2'd2, 4'h0, 4'h0, r);
    chk("pin_1010", r, 4'b1010);

    // Masked write from requester 1.
    access(1, 1'b1, 2'd1, 4'b0101, 4'b0011, r);
    chk("masked_1001", gpio_write, 4'b1001);

    // Reads of DIR, OUT and reserved.
    access(0, 1'b1, 2'd0, 4'b0101, 4'b1111, r);
    access(1, 1'b1, 2'd1, 4'b1100, 4'b1111, r);
    access(1, 1'b0, 2'd0, 4'h0, 4'h0, r);
    chk("rd_dir", r, 4'b0101);
    access(0, 1'b0, 2'd1, 4'h0, 4'h0, r);
    chk("rd_out", r, 4'b1100);
    access(1, 1'b0, 2'd3, 4'h0, 4'h0, r);
    chk("rd_rsvd", r, 4'b0000);
    access(0, 1'b1, 2'd2, 4'b1111, 4'b1111, r);
    chk("pinw_regs", {gpio_dir, gpio_write}, 8'b0101_1100);

    // Async reset in the middle of an ACCESS write.
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd0;
    wdata0 = 4'b1111; mask0 = 4'b1111;
    tick();
    #3;
    rst = 1'b0;
    req0 = 1'b0;
    #1;
    chk("arst_dir", gpio_dir, 4'h0);
    chk("arst_out", gpio_write, 4'h0);
    chk("arst_done", {done0, done1, gnt0, gnt1}, 4'h0);
    tick();
    chk("arst_hold", gpio_dir, 4'h0);
    rst = 1'b1;
    tick();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
    tick();
    chk("arst_first", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
